// File: rtl/pr_hrav_icap_loader_pkg.sv
// Shared constants and types for the ICAP partial-reconfiguration loader.
// Header bit positions match the dispatcher's packet format.
package pr_hrav_icap_loader_pkg;

    localparam int HDR_CORE_SEL   = 26;
    localparam int HDR_EOB        = 28;
    localparam int HDR_DST_HI     = 25;
    localparam int HDR_DST_LO     = 24;

    localparam int ICAP_WORD_W    = 32;
    localparam int WORDS_PER_BEAT = 8;
    localparam int IDX_W          = 3;

    typedef enum logic [1:0] {
        S_HDR    = 2'd0,
        S_DATA   = 2'd1,
        S_SHIFT  = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

endpackage

// File: rtl/pr_hrav_icap_ser.sv
// Beat serialiser: holds one 256-bit data beat plus strobes and presents one
// 32-bit slot per advance, with strobe-nibble classification and byte bitswap.
module pr_hrav_icap_ser
    import pr_hrav_icap_loader_pkg::*;
#(
    parameter int C_DATA_WIDTH   = 256,
    parameter bit C_ICAP_BITSWAP = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      advance,
    input  logic [C_DATA_WIDTH-1:0]   data,
    input  logic [C_DATA_WIDTH/8-1:0] strb,
    output logic [IDX_W-1:0]          idx,
    output logic [ICAP_WORD_W-1:0]    word,
    output logic                      slot_write,
    output logic                      slot_bad
);

    localparam int STRB_W = C_DATA_WIDTH / 8;

    logic [C_DATA_WIDTH-1:0] data_reg;
    logic [STRB_W-1:0]       strb_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [ICAP_WORD_W-1:0]  raw_word;
    logic [3:0]              nibble;

    // The current slot always sits in the low word, so shifting walks word 0..7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            strb_reg <= '0;
            idx_reg  <= '0;
        end else if (load) begin
            data_reg <= data;
            strb_reg <= strb;
            idx_reg  <= '0;
        end else if (advance) begin
            data_reg <= data_reg >> ICAP_WORD_W;
            strb_reg <= strb_reg >> 4;
            idx_reg  <= idx_reg + 1'b1;
        end
    end

    assign idx        = idx_reg;
    assign raw_word   = data_reg[ICAP_WORD_W-1:0];
    assign nibble     = strb_reg[3:0];
    assign slot_write = (nibble == 4'hF);
    assign slot_bad   = (nibble != 4'h0) && (nibble != 4'hF);

    // ICAPE2 expects each byte with its bit order reversed.
    generate
        if (C_ICAP_BITSWAP) begin : g_swap
            for (genvar gi = 0; gi < ICAP_WORD_W / 8; gi++) begin : g_byte
                for (genvar gj = 0; gj < 8; gj++) begin : g_bit
                    assign word[8*gi+gj] = raw_word[8*gi+7-gj];
                end
            end
        end else begin : g_noswap
            assign word = raw_word;
        end
    endgenerate

endmodule

// File: rtl/pr_hrav_icap_loader.sv
// Streams partial bitstreams from the dispatcher into ICAPE2 and manages the
// decouple/settle/re-enable handshake of the scanner core being reconfigured.
module pr_hrav_icap_loader
    import pr_hrav_icap_loader_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter bit C_ICAP_BITSWAP      = 1'b1,
    parameter int C_SETTLE_CYCLES     = 16
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                             S_AXIS_TVALID,
    input  logic [127:0]                     S_AXIS_TUSER,
    input  logic                             S_AXIS_TLAST,
    output logic                             S_AXIS_TREADY,
    output logic                             ICAP_CSIB,
    output logic                             ICAP_RDWRB,
    output logic [31:0]                      ICAP_I,
    output logic                             core_0_enb,
    output logic                             core_1_enb,
    output logic                             pr_busy,
    output logic                             pr_done,
    output logic [1:0]                       pr_err,
    output logic [31:0]                      pr_word_cnt
);

    localparam int SETTLE_W = (C_SETTLE_CYCLES > 1) ? $clog2(C_SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(C_SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(WORDS_PER_BEAT - 1);

    state_t                 state_reg, state_next;
    logic                   tready_reg, tready_next;
    logic                   csib_reg, csib_next;
    logic [31:0]            icap_reg, icap_next;
    logic                   core0_reg, core0_next;
    logic                   core1_reg, core1_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic [1:0]             err_reg, err_next;
    logic [31:0]            cnt_reg, cnt_next;
    logic                   sel_reg, sel_next;
    logic                   eob_reg, eob_next;
    logic                   last_reg, last_next;
    logic [SETTLE_W-1:0]    settle_reg, settle_next;

    logic                   accept;
    logic                   hdr_sel;
    logic                   hdr_eob;
    logic                   ser_load;
    logic                   ser_advance;
    logic [IDX_W-1:0]       ser_idx;
    logic [IDX_W-1:0]       idx_next;
    logic [ICAP_WORD_W-1:0] ser_word;
    logic                   slot_write;
    logic                   slot_bad;
    logic                   unused_tuser;

    assign unused_tuser = ^S_AXIS_TUSER;
    assign accept       = S_AXIS_TVALID & tready_reg;
    assign hdr_sel      = S_AXIS_TDATA[HDR_CORE_SEL];
    assign hdr_eob      = S_AXIS_TDATA[HDR_EOB];

    pr_hrav_icap_ser #(
        .C_DATA_WIDTH   (C_S_AXIS_DATA_WIDTH),
        .C_ICAP_BITSWAP (C_ICAP_BITSWAP)
    ) u_ser (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .load       (ser_load),
        .advance    (ser_advance),
        .data       (S_AXIS_TDATA),
        .strb       (S_AXIS_TSTRB),
        .idx        (ser_idx),
        .word       (ser_word),
        .slot_write (slot_write),
        .slot_bad   (slot_bad)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg  <= S_HDR;
            tready_reg <= 1'b0;
            csib_reg   <= 1'b1;
            icap_reg   <= '0;
            core0_reg  <= 1'b1;
            core1_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= '0;
            cnt_reg    <= '0;
            sel_reg    <= 1'b0;
            eob_reg    <= 1'b0;
            last_reg   <= 1'b0;
            settle_reg <= '0;
        end else begin
            state_reg  <= state_next;
            tready_reg <= tready_next;
            csib_reg   <= csib_next;
            icap_reg   <= icap_next;
            core0_reg  <= core0_next;
            core1_reg  <= core1_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            cnt_reg    <= cnt_next;
            sel_reg    <= sel_next;
            eob_reg    <= eob_next;
            last_reg   <= last_next;
            settle_reg <= settle_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        tready_next = 1'b0;
        csib_next   = 1'b1;
        icap_next   = icap_reg;
        core0_next  = core0_reg;
        core1_next  = core1_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        err_next    = err_reg;
        cnt_next    = cnt_reg;
        sel_next    = sel_reg;
        eob_next    = eob_reg;
        last_next   = last_reg;
        settle_next = '0;
        ser_load    = 1'b0;
        ser_advance = 1'b0;

        case (state_reg)
            S_HDR: begin
                if (accept) begin
                    eob_next = hdr_eob;
                    if (!busy_reg) begin
                        busy_next = 1'b1;
                        cnt_next  = '0;
                        sel_next  = hdr_sel;
                        if (hdr_sel) core1_next = 1'b0;
                        else         core0_next = 1'b0;
                    end else if (hdr_sel != sel_reg) begin
                        // The session core stays decoupled; the new select is only flagged.
                        err_next[1] = 1'b1;
                    end
                    if (S_AXIS_TLAST) state_next = hdr_eob ? S_SETTLE : S_HDR;
                    else              state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    ser_load   = 1'b1;
                    last_next  = S_AXIS_TLAST;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                ser_advance = 1'b1;
                if (slot_write) begin
                    csib_next = 1'b0;
                    icap_next = ser_word;
                    if (cnt_reg != '1) cnt_next = cnt_reg + 32'd1;
                end else if (slot_bad) begin
                    err_next[0] = 1'b1;
                end
                if (ser_idx == IDX_LAST) begin
                    if (accept) begin
                        ser_load  = 1'b1;
                        last_next = S_AXIS_TLAST;
                    end else if (last_reg) begin
                        state_next = eob_reg ? S_SETTLE : S_HDR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_reg == SETTLE_LAST) begin
                    if (sel_reg) core1_next = 1'b1;
                    else         core0_next = 1'b1;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = S_HDR;
                end else begin
                    settle_next = settle_reg + 1'b1;
                end
            end
            default: state_next = S_HDR;
        endcase

        // TREADY is registered, so it is derived from where the FSM will be next cycle.
        if (ser_load)         idx_next = '0;
        else if (ser_advance) idx_next = ser_idx + 1'b1;
        else                  idx_next = ser_idx;

        case (state_next)
            S_HDR, S_DATA: tready_next = 1'b1;
            S_SHIFT:       tready_next = (idx_next == IDX_LAST) && !last_next;
            default:       tready_next = 1'b0;
        endcase
    end

    assign S_AXIS_TREADY = tready_reg;
    assign ICAP_CSIB     = csib_reg;
    assign ICAP_RDWRB    = 1'b0;
    assign ICAP_I        = icap_reg;
    assign core_0_enb    = core0_reg;
    assign core_1_enb    = core1_reg;
    assign pr_busy       = busy_reg;
    assign pr_done       = done_reg;
    assign pr_err        = err_reg;
    assign pr_word_cnt   = cnt_reg;

endmodule

// File: tb/tb_pr_hrav_icap_loader.sv
// Self-checking bench for pr_hrav_icap_loader: directed scenarios plus random
// packets compared against a packet-level reference model.
module tb_pr_hrav_icap_loader;

    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic [255:0] S_AXIS_TDATA;
    logic [31:0]  S_AXIS_TSTRB;
    logic         S_AXIS_TVALID;
    logic [127:0] S_AXIS_TUSER;
    logic         S_AXIS_TLAST;
    logic         S_AXIS_TREADY;
    logic         ICAP_CSIB;
    logic         ICAP_RDWRB;
    logic [31:0]  ICAP_I;
    logic         core_0_enb;
    logic         core_1_enb;
    logic         pr_busy;
    logic         pr_done;
    logic [1:0]   pr_err;
    logic [31:0]  pr_word_cnt;

    pr_hrav_icap_loader dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TSTRB  (S_AXIS_TSTRB),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TUSER  (S_AXIS_TUSER),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .ICAP_CSIB     (ICAP_CSIB),
        .ICAP_RDWRB    (ICAP_RDWRB),
        .ICAP_I        (ICAP_I),
        .core_0_enb    (core_0_enb),
        .core_1_enb    (core_1_enb),
        .pr_busy       (pr_busy),
        .pr_done       (pr_done),
        .pr_err        (pr_err),
        .pr_word_cnt   (pr_word_cnt)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Monitor-owned observations (only the monitor writes these).
    int          cyc = 0;
    logic [31:0] obs_q[$];
    int          obs_cyc[$];
    int          done_n = 0;
    int          done_cyc = 0;
    logic        done_c0 = 1'b0;
    int          c0_low_n = 0;
    int          c1_low_n = 0;

    // Reference model state (only the stimulus block writes these).
    logic [31:0]  exp_q[$];
    int           exp_done = 0;
    int           rd = 0;
    bit           m_busy = 1'b0;
    bit           m_sel = 1'b0;
    logic [1:0]   m_err = 2'b00;
    int unsigned  m_cnt = 0;
    logic [255:0] beat_data[4];
    logic [31:0]  beat_strb[4];
    int           last_acc = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (!ICAP_CSIB) begin
                obs_q.push_back(ICAP_I);
                obs_cyc.push_back(cyc);
            end
            if (pr_done) begin
                done_n   = done_n + 1;
                done_cyc = cyc;
                done_c0  = core_0_enb;
            end
            if (!core_0_enb) c0_low_n = c0_low_n + 1;
            if (!core_1_enb) c1_low_n = c1_low_n + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8; i++)
                r[8*b+i] = w[8*b+7-i];
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] make_hdr(input bit sel, input bit eob);
        logic [255:0] h;
        h = rand256();
        h[28] = eob;
        h[26] = sel;
        h[25:24] = 2'b11;
        return h;
    endfunction

    task automatic send_beat(input logic [255:0] d, input logic [31:0] s, input logic l, output int acc);
        int n;
        n = 0;
        acc = -1;
        S_AXIS_TDATA  = d;
        S_AXIS_TSTRB  = s;
        S_AXIS_TLAST  = l;
        S_AXIS_TUSER  = {$urandom, $urandom, $urandom, $urandom};
        S_AXIS_TVALID = 1'b1;
        while (acc < 0 && n < 200) begin
            @(negedge ACLK);
            if (S_AXIS_TREADY) begin
                @(posedge ACLK);
                #1;
                acc = cyc;
            end
            n++;
        end
        S_AXIS_TVALID = 1'b0;
        check("beat_accepted", (acc >= 0), 1'b1);
    endtask

    // Packet-level model: session starts at first header when idle, ends after an eob packet.
    task automatic model_packet(input bit sel, input bit eob, input int nb);
        logic [3:0] nib;
        if (!m_busy) begin
            m_busy = 1'b1;
            m_sel  = sel;
            m_cnt  = 0;
        end else if (sel != m_sel) begin
            m_err[1] = 1'b1;
        end
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 8; k++) begin
                nib = beat_strb[b][4*k +: 4];
                if (nib == 4'hF) begin
                    exp_q.push_back(swap32(beat_data[b][32*k +: 32]));
                    m_cnt++;
                end else if (nib != 4'h0) begin
                    m_err[0] = 1'b1;
                end
            end
        end
        if (eob) begin
            m_busy = 1'b0;
            exp_done++;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_n < exp_done && n < 400) begin
            @(posedge ACLK);
            #2;
            n++;
        end
        check({tag, "_done_count"}, done_n, exp_done);
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    task automatic run_packet(input bit sel, input bit eob, input int nb, input bit gaps);
        int a;
        send_beat(make_hdr(sel, eob), 32'hFFFF_FFFF, (nb == 0), a);
        for (int b = 0; b < nb; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) @(posedge ACLK);
                #1;
            end
            send_beat(beat_data[b], beat_strb[b], (b == nb - 1), a);
            last_acc = a;
        end
        model_packet(sel, eob, nb);
        if (eob) wait_done("pkt");
        else begin
            repeat (12) @(posedge ACLK);
            #1;
        end
    endtask

    task automatic check_writes(input string tag);
        int n;
        n = obs_q.size() - rd;
        check({tag, "_write_count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check({tag, "_word"}, obs_q[rd+i], exp_q[i]);
        rd = obs_q.size();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_cnt"},  pr_word_cnt, m_cnt);
        check({tag, "_err"},  pr_err, m_err);
        check({tag, "_busy"}, pr_busy, m_busy);
        check({tag, "_c0"},   core_0_enb, !(m_busy && !m_sel));
        check({tag, "_c1"},   core_1_enb, !(m_busy && m_sel));
        check({tag, "_rdwrb"}, ICAP_RDWRB, 1'b0);
    endtask

    initial begin
        int a;
        int base_n;
        int base_c;
        bit eob;
        int nb;
        int r;

        ARESETN       = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TSTRB  = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TUSER  = '0;
        S_AXIS_TLAST  = 1'b0;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_tready", S_AXIS_TREADY, 1'b0);
        check("rst_csib",   ICAP_CSIB, 1'b1);
        check("rst_rdwrb",  ICAP_RDWRB, 1'b0);
        check("rst_icap_i", ICAP_I, 32'h0);
        check("rst_c0",     core_0_enb, 1'b1);
        check("rst_c1",     core_1_enb, 1'b1);
        check("rst_busy",   pr_busy, 1'b0);
        check("rst_done",   pr_done, 1'b0);
        check("rst_err",    pr_err, 2'b00);
        check("rst_cnt",    pr_word_cnt, 32'h0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;

        // 1: single full beat, core 0, end of bitstream
        beat_data[0] = rand256();
        beat_data[0][31:0] = 32'hAA99_5566;
        beat_strb[0] = 32'hFFFF_FFFF;
        send_beat(make_hdr(1'b0, 1'b1), 32'hFFFF_FFFF, 1'b0, a);
        check("t1_c0_after_hdr", core_0_enb, 1'b0);
        check("t1_busy_after_hdr", pr_busy, 1'b1);
        send_beat(beat_data[0], beat_strb[0], 1'b1, a);
        model_packet(1'b0, 1'b1, 1);
        wait_done("t1");
        check("t1_writes", obs_q.size() - rd, 8);
        if (obs_q.size() > rd) begin
            check("t1_first_word", obs_q[rd], 32'h5599_AA66);
            check("t1_latency", obs_cyc[rd] - a, 1);
            check("t1_burst_span", obs_cyc[obs_q.size()-1] - obs_cyc[rd], 7);
            check("t1_settle", done_cyc - obs_cyc[obs_q.size()-1], 16);
        end
        check("t1_c0_at_done", done_c0, 1'b1);
        check("t1_done_low", pr_done, 1'b0);
        check_writes("t1");
        check_status("t1");

        // 2: partial strobes
        beat_data[0] = rand256();
        beat_strb[0] = 32'h0000_0FFF;
        run_packet(1'b0, 1'b1, 1, 1'b0);
        check("t2a_writes", obs_q.size() - rd, 3);
        check_writes("t2a");
        check_status("t2a");
        beat_data[0] = rand256();
        beat_strb[0] = 32'h0000_00F7;
        run_packet(1'b0, 1'b1, 1, 1'b0);
        check("t2b_writes", obs_q.size() - rd, 1);
        check("t2b_err0", pr_err[0], 1'b1);
        check_writes("t2b");
        check_status("t2b");

        // 3: core 1, two packets in one session
        base_n = done_n;
        base_c = c0_low_n;
        beat_data[0] = rand256();
        beat_strb[0] = 32'hFFFF_FFFF;
        run_packet(1'b1, 1'b0, 1, 1'b0);
        check("t3_c1_between", core_1_enb, 1'b0);
        check("t3_no_done_between", done_n - base_n, 0);
        check_writes("t3a");
        check_status("t3a");
        beat_data[0] = rand256();
        run_packet(1'b1, 1'b1, 1, 1'b0);
        check("t3_single_done", done_n - base_n, 1);
        check("t3_c0_never_low", c0_low_n - base_c, 0);
        check_writes("t3b");
        check_status("t3b");

        // 4: back-to-back 3-beat packet
        for (int b = 0; b < 3; b++) begin
            beat_data[b] = rand256();
            beat_strb[b] = 32'hFFFF_FFFF;
        end
        run_packet(1'b0, 1'b1, 3, 1'b0);
        check("t4_writes", obs_q.size() - rd, 24);
        if (obs_q.size() > rd)
            check("t4_no_bubble", obs_cyc[obs_q.size()-1] - obs_cyc[rd], 23);
        check_writes("t4");
        check_status("t4");

        // 6: header-only session, then a session whose select flips
        run_packet(1'b0, 1'b1, 0, 1'b0);
        check_writes("t6a");
        check_status("t6a");
        base_c = c1_low_n;
        beat_data[0] = rand256();
        beat_strb[0] = 32'hFFFF_FFFF;
        run_packet(1'b0, 1'b0, 1, 1'b1);
        beat_data[0] = rand256();
        run_packet(1'b1, 1'b1, 1, 1'b1);
        check("t6_err1", pr_err[1], 1'b1);
        check("t6_c1_never_low", c1_low_n - base_c, 0);
        check_writes("t6b");
        check_status("t6b");

        // Random packets
        for (int p = 0; p < 16; p++) begin
            nb  = $urandom_range(0, 3);
            eob = (p % 3 == 2) || (p == 15);
            for (int b = 0; b < nb; b++) begin
                beat_data[b] = rand256();
                for (int k = 0; k < 8; k++) begin
                    r = $urandom_range(0, 19);
                    if (r < 14)      beat_strb[b][4*k +: 4] = 4'hF;
                    else if (r < 18) beat_strb[b][4*k +: 4] = 4'h0;
                    else             beat_strb[b][4*k +: 4] = 4'($urandom_range(1, 14));
                end
            end
            run_packet(1'($urandom_range(0, 1)), eob, nb, 1'b1);
            check_writes("rnd");
            check_status("rnd");
        end

        // 5: asynchronous reset in the middle of a beat
        beat_data[0] = rand256();
        send_beat(make_hdr(1'b0, 1'b1), 32'hFFFF_FFFF, 1'b0, a);
        send_beat(beat_data[0], 32'hFFFF_FFFF, 1'b1, a);
        repeat (4) @(posedge ACLK);
        #2;
        check("t5_pre_csib", ICAP_CSIB, 1'b0);
        ARESETN = 1'b0;
        #1;
        check("t5_rst_csib", ICAP_CSIB, 1'b1);
        check("t5_rst_c0", core_0_enb, 1'b1);
        check("t5_rst_c1", core_1_enb, 1'b1);
        check("t5_rst_busy", pr_busy, 1'b0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        m_busy = 1'b0;
        m_err  = 2'b00;
        m_cnt  = 0;
        exp_q.delete();
        rd = obs_q.size();
        check_status("t5_after_rst");
        for (int b = 0; b < 2; b++) begin
            beat_data[b] = rand256();
            beat_strb[b] = 32'hFFFF_FFFF;
        end
        run_packet(1'b1, 1'b1, 2, 1'b0);
        check_writes("t5_next");
        check_status("t5_next");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
